// File: rtl/conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd
//
// Sequential binary-to-BCD converter (shift-and-add-3). Converts an unsigned
// ANCHO-bit value into four BCD digits (units .. thousands) for the 7-segment
// display controller. Holds the last result stable between conversions and
// flags values above 9999.
//
// Parameters:
//   ANCHO       width of i_Binario, 1..14
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Rst       asynchronous reset, active-low
//   i_Inicio    conversion request, sampled only while idle (REPOSO)
//   i_Binario   unsigned value, captured on the accepting edge
//   o_Ocupado   high while a conversion is in progress
//   o_Listo     one-cycle pulse: new digits valid
//   o_Desborde  last accepted value was > 9999, held until next completion
//   o_Datos1    units digit
//   o_Datos2    tens digit
//   o_Datos3    hundreds digit
//   o_Datos4    thousands digit
//
// Build option:
//   BCD_SATURA_EN  defined   : values > 9999 are clamped to 9999 before
//                              conversion (digits 9,9,9,9).
//                  undefined : values > 9999 are converted as-is internally,
//                              but the digits are forced to 4'hF on output.
//   In both cases o_Desborde is set and latency is identical.
// -----------------------------------------------------------------------------
module conversor_bin_bcd #(
    parameter int ANCHO = 14
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Inicio,
    input  logic [ANCHO-1:0] i_Binario,
    output logic             o_Ocupado,
    output logic             o_Listo,
    output logic             o_Desborde,
    output logic [3:0]       o_Datos1,
    output logic [3:0]       o_Datos2,
    output logic [3:0]       o_Datos3,
    output logic [3:0]       o_Datos4
);

    localparam int             W       = 14;
    localparam logic [W-1:0]   MAX_BCD = 14'd9999;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [W-1:0]  bin_q, bin_d;       // value being shifted out, MSB at ANCHO-1
    logic [15:0]   bcd_q, bcd_d;       // BCD scratch, four nibbles
    logic [3:0]    cnt_q, cnt_d;       // shifts remaining
    logic          ovf_q, ovf_d;       // accepted value exceeded 9999
    logic [15:0]   datos_q, datos_d;   // registered digits {thousands..units}
    logic          listo_q, listo_d;
    logic          desb_q, desb_d;

    logic [W-1:0]  bin_ext;
    logic [15:0]   bcd_adj;
    logic          bit_entra;

    assign bin_ext   = W'(i_Binario);
    assign bit_entra = bin_q[ANCHO-1];

    // Add 3 to every nibble that is 5 or more, so that the following shift
    // carries correctly into the next decimal digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_suma3
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5)
                                        ? bcd_q[gi*4 +: 4] + 4'd3
                                        : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        estado_d = estado_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        datos_d  = datos_q;
        listo_d  = 1'b0;
        desb_d   = desb_q;

        case (estado_q)
            REPOSO: begin
                if (i_Inicio) begin
                    ovf_d = (bin_ext > MAX_BCD);
`ifdef BCD_SATURA_EN
                    bin_d = (bin_ext > MAX_BCD) ? MAX_BCD : bin_ext;
`else
                    bin_d = bin_ext;
`endif
                    bcd_d    = 16'd0;
                    cnt_d    = 4'(ANCHO);
                    estado_d = DESPLAZA;
                end
            end

            DESPLAZA: begin
                bcd_d = {bcd_adj[14:0], bit_entra};
                bin_d = {bin_q[W-2:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    estado_d = FIN;
                end
            end

            FIN: begin
`ifdef BCD_SATURA_EN
                datos_d = bcd_q;
`else
                // Out-of-range values still run through the shifter (so latency
                // does not depend on the value) but are blanked to F digits.
                datos_d = ovf_q ? 16'hFFFF : bcd_q;
`endif
                desb_d   = ovf_q;
                listo_d  = 1'b1;
                estado_d = REPOSO;
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            estado_q <= REPOSO;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            datos_q  <= '0;
            listo_q  <= 1'b0;
            desb_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            datos_q  <= datos_d;
            listo_q  <= listo_d;
            desb_q   <= desb_d;
        end
    end

    assign o_Ocupado  = (estado_q != REPOSO);
    assign o_Listo    = listo_q;
    assign o_Desborde = desb_q;
    assign o_Datos1   = datos_q[3:0];
    assign o_Datos2   = datos_q[7:4];
    assign o_Datos3   = datos_q[11:8];
    assign o_Datos4   = datos_q[15:12];

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// -----------------------------------------------------------------------------
// tb_conversor_bin_bcd
//
// Directed bench for conversor_bin_bcd: a 14-bit instance for the main
// sequence and an 8-bit instance for the narrow-width case. Expected digits
// are written as hex words {thousands, hundreds, tens, units}.
// -----------------------------------------------------------------------------
module tb_conversor_bin_bcd;

    logic        clk;
    logic        rst_n;
    logic        inicio;
    logic [13:0] bin;
    logic        ocupado, listo, desb;
    logic [3:0]  d1, d2, d3, d4;

    logic        inicio8;
    logic [7:0]  bin8;
    logic        ocupado8, listo8, desb8;
    logic [3:0]  e1, e2, e3, e4;

    int n_checks = 0;
    int n_fail   = 0;
    int listo_cnt = 0;

`ifdef BCD_SATURA_EN
    localparam logic [15:0] EXP_OVF = 16'h9999;
`else
    localparam logic [15:0] EXP_OVF = 16'hFFFF;
`endif

    conversor_bin_bcd #(.ANCHO(14)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_Inicio   (inicio),
        .i_Binario  (bin),
        .o_Ocupado  (ocupado),
        .o_Listo    (listo),
        .o_Desborde (desb),
        .o_Datos1   (d1),
        .o_Datos2   (d2),
        .o_Datos3   (d3),
        .o_Datos4   (d4)
    );

    conversor_bin_bcd #(.ANCHO(8)) dut8 (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_Inicio   (inicio8),
        .i_Binario  (bin8),
        .o_Ocupado  (ocupado8),
        .o_Listo    (listo8),
        .o_Desborde (desb8),
        .o_Datos1   (e1),
        .o_Datos2   (e2),
        .o_Datos3   (e3),
        .o_Datos4   (e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (listo === 1'b1) listo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a value with a one-cycle request; returns just after the
    // accepting edge (at the following falling edge).
    task automatic launch(input logic [13:0] v);
        bin    = v;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    // Counts falling edges until o_Listo, and how many of them saw o_Ocupado.
    task automatic wait_listo(output int n, output int busy);
        n    = 0;
        busy = 0;
        while (listo !== 1'b1 && n < 40) begin
            if (ocupado === 1'b1) busy++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert(input string tag, input logic [13:0] v,
                           input logic [15:0] exp_dig, input logic exp_desb);
        int n, busy;
        launch(v);
        wait_listo(n, busy);
        $display("conv %-6s in=%0d digits=%h%h%h%h desb=%0b lat=%0d", tag, v, d4, d3, d2, d1, desb, n);
        check({tag, "_lat"},   n, 15);
        check({tag, "_busy"},  busy, 15);
        check({tag, "_dig"},   {d4, d3, d2, d1}, exp_dig);
        check({tag, "_desb"},  desb, exp_desb);
        check({tag, "_ocup"},  ocupado, 1'b0);
    endtask

    initial begin
        int n, busy, cnt_before;

        rst_n   = 1'b0;
        inicio  = 1'b0;
        bin     = '0;
        inicio8 = 1'b0;
        bin8    = '0;
        repeat (3) @(negedge clk);
        check("rst_dig",   {d4, d3, d2, d1}, 16'h0000);
        check("rst_ocup",  ocupado, 1'b0);
        check("rst_listo", listo, 1'b0);
        check("rst_desb",  desb, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversion, then pulse must drop after one cycle.
        convert("c1234", 14'd1234, 16'h1234, 1'b0);
        @(negedge clk);
        check("c1234_listo_off", listo, 1'b0);

        // Back-to-back: each new request issued in the o_Listo cycle.
        convert("c0",    14'd0,    16'h0000, 1'b0);
        convert("c9",    14'd9,    16'h0009, 1'b0);
        convert("c10",   14'd10,   16'h0010, 1'b0);
        convert("c999",  14'd999,  16'h0999, 1'b0);
        convert("c9999", 14'd9999, 16'h9999, 1'b0);
        @(negedge clk);
        check("b2b_listo_off", listo, 1'b0);

        // Overflow, then a normal value clears the flag.
        convert("c16383", 14'd16383, EXP_OVF, 1'b1);
        convert("c42",    14'd42,    16'h0042, 1'b0);
        @(negedge clk);

        // Request during a conversion is ignored.
        cnt_before = listo_cnt;
        launch(14'd5678);
        repeat (4) @(negedge clk);
        check("busy_hold_dig", {d4, d3, d2, d1}, 16'h0042);
        launch(14'd1111);
        wait_listo(n, busy);
        $display("conv ign    in=5678 digits=%h%h%h%h desb=%0b lat=%0d", d4, d3, d2, d1, desb, n);
        check("ign_lat", n, 10);
        check("ign_dig", {d4, d3, d2, d1}, 16'h5678);
        repeat (20) @(negedge clk);
        check("ign_single_listo", listo_cnt - cnt_before, 1);

        // Asynchronous reset mid-conversion.
        launch(14'd4321);
        repeat (6) @(negedge clk);
        cnt_before = listo_cnt;
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-conversion digits=%h%h%h%h ocup=%0b", d4, d3, d2, d1, ocupado);
        check("arst_dig",  {d4, d3, d2, d1}, 16'h0000);
        check("arst_ocup", ocupado, 1'b0);
        check("arst_desb", desb, 1'b0);
        repeat (20) @(negedge clk);
        check("arst_no_listo", listo_cnt - cnt_before, 0);
        rst_n = 1'b1;
        @(negedge clk);
        convert("c77", 14'd77, 16'h0077, 1'b0);

        // Narrow instance.
        bin8    = 8'd255;
        inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        n = 0;
        while (listo8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        $display("conv w8     in=255 digits=%h%h%h%h desb=%0b lat=%0d", e4, e3, e2, e1, desb8, n);
        check("w8_lat",  n, 9);
        check("w8_dig",  {e4, e3, e2, e1}, 16'h0255);
        check("w8_desb", desb8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
